// File: rtl/scie_fir_pkg.sv
// Shared definitions for the SCIE FIR sequencer.
// Holds the SCIE opcode words, the sequencer state encoding and the default
// frame geometry (taps per frame, result latency of the SCIE pipeline).
package scie_fir_pkg;

  localparam int DEFAULT_TAPS           = 5;
  localparam int DEFAULT_RESULT_LATENCY = 1;

  localparam logic [31:0] OP_LD_COEF   = 32'h0000_000B;
  localparam logic [31:0] OP_LD_SAMPLE = 32'h0000_002B;
  localparam logic [31:0] OP_COMPUTE   = 32'h0000_005B;

  typedef enum logic [2:0] {
    ST_ACCEPT  = 3'd0,
    ST_ISSUE_C = 3'd1,
    ST_ISSUE_S = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_WAIT    = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

endpackage

// File: rtl/scie_fir_sequencer.sv
// SCIE FIR sequencer.
// Accepts TAPS coefficient/sample pairs, streams each pair to the SCIE
// pipeline as a load-coefficient and a load-sample instruction, issues one
// compute instruction, waits RESULT_LATENCY cycles for the result and holds
// it on the output until downstream takes it.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   in_valid/in_ready       pair handshake; in_coef, in_sample are the pair
//   scie_valid              instruction issue strobe; scie_insn/rs1/rs2 are
//                           the instruction word and operands (0 when idle)
//   scie_rd                 signed result returned by the SCIE pipeline
//   out_valid/out_ready     result handshake; out_result is the FIR result
//   busy                    low only when idle at the start of a frame
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ACCEPT  | waiting for the pair at tap idx
// ST_ISSUE_C | issuing load-coefficient for tap idx
// ST_ISSUE_S | issuing load-sample for tap idx; last tap heads to compute
// ST_COMPUTE | issuing the compute instruction (one cycle)
// ST_WAIT    | waiting for the SCIE result; captured on the last cycle
// ST_HOLD    | presenting out_result until out_ready
module scie_fir_sequencer
  import scie_fir_pkg::*;
#(
  parameter int TAPS           = DEFAULT_TAPS,            // 1..16
  parameter int RESULT_LATENCY = DEFAULT_RESULT_LATENCY   // 1..4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_coef,
  input  logic [15:0] in_sample,
  output logic        scie_valid,
  output logic [31:0] scie_insn,
  output logic [31:0] scie_rs1,
  output logic [31:0] scie_rs2,
  input  logic [31:0] scie_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  localparam logic [3:0] LAST_IDX = 4'(TAPS - 1);
  // WAIT counts down to zero, so it is loaded with one less than its length.
  localparam logic [1:0] LAT_LOAD = 2'(RESULT_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  idx;
  logic [1:0]  lat_cnt;
  logic [15:0] coef_q;
  logic [15:0] sample_q;
  logic [31:0] result_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_ACCEPT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCEPT:  if (in_valid) state_nxt = ST_ISSUE_C;
      ST_ISSUE_C: state_nxt = ST_ISSUE_S;
      ST_ISSUE_S: state_nxt = (idx == LAST_IDX) ? ST_COMPUTE : ST_ACCEPT;
      ST_COMPUTE: state_nxt = ST_WAIT;
      ST_WAIT:    if (lat_cnt == 2'd0) state_nxt = ST_HOLD;
      ST_HOLD:    if (out_ready) state_nxt = ST_ACCEPT;
      default:    state_nxt = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      lat_cnt  <= '0;
      coef_q   <= '0;
      sample_q <= '0;
      result_q <= '0;
    end else begin
      if (state == ST_ACCEPT && in_valid) begin
        coef_q   <= in_coef;
        sample_q <= in_sample;
      end

      // idx stays on the last tap through compute/wait/hold so busy stays
      // high, and returns to zero only on the result handshake.
      if (state == ST_ISSUE_S && idx != LAST_IDX) begin
        idx <= idx + 4'd1;
      end else if (state == ST_HOLD && out_ready) begin
        idx <= '0;
      end

      if (state == ST_COMPUTE) begin
        lat_cnt <= LAT_LOAD;
      end else if (state == ST_WAIT && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end

      // Result is taken bit-exact on the terminal WAIT cycle.
      if (state == ST_WAIT && lat_cnt == 2'd0) begin
        result_q <= scie_rd;
      end
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    scie_valid = 1'b0;
    scie_insn  = '0;
    scie_rs1   = '0;
    scie_rs2   = '0;
    out_valid  = 1'b0;
    busy       = !(state == ST_ACCEPT && idx == 4'd0);
    case (state)
      ST_ACCEPT: in_ready = 1'b1;
      ST_ISSUE_C: begin
        scie_valid = 1'b1;
        scie_insn  = OP_LD_COEF;
        scie_rs1   = {16'b0, coef_q};
        scie_rs2   = {28'b0, idx};
      end
      ST_ISSUE_S: begin
        scie_valid = 1'b1;
        scie_insn  = OP_LD_SAMPLE;
        scie_rs1   = {16'b0, sample_q};
        scie_rs2   = {28'b0, idx};
      end
      ST_COMPUTE: begin
        scie_valid = 1'b1;
        scie_insn  = OP_COMPUTE;
      end
      ST_HOLD: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_result = result_q;

endmodule

// File: tb/tb_scie_fir_sequencer.sv
`timescale 1ns/1ps
module tb_scie_fir_sequencer;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } issue_t;

  localparam logic [31:0] JUNK = 32'h0BAD_F00D;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int     total = 0;
  int     bad   = 0;
  bit     chk_en = 1'b0;
  issue_t exp_q[$];
  issue_t obs_q[$];

  // default instance: TAPS=5, RESULT_LATENCY=1
  logic        a_reset, a_in_valid, a_in_ready, a_scie_valid, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_in_coef, a_in_sample;
  logic [31:0] a_scie_insn, a_scie_rs1, a_scie_rs2, a_scie_rd, a_out_result;
  logic [31:0] a_rd_val;
  int          a_pend = 0;

  // short instance: TAPS=1, RESULT_LATENCY=3
  logic        b_reset, b_in_valid, b_in_ready, b_scie_valid, b_out_valid, b_out_ready, b_busy;
  logic [15:0] b_in_coef, b_in_sample;
  logic [31:0] b_scie_insn, b_scie_rs1, b_scie_rs2, b_scie_rd, b_out_result;
  logic [31:0] b_rd_val;
  int          b_pend = 0;

  scie_fir_sequencer dut_a (
    .clock(clock), .reset(a_reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_coef(a_in_coef), .in_sample(a_in_sample),
    .scie_valid(a_scie_valid), .scie_insn(a_scie_insn), .scie_rs1(a_scie_rs1), .scie_rs2(a_scie_rs2),
    .scie_rd(a_scie_rd),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result), .busy(a_busy)
  );

  scie_fir_sequencer #(.TAPS(1), .RESULT_LATENCY(3)) dut_b (
    .clock(clock), .reset(b_reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_coef(b_in_coef), .in_sample(b_in_sample),
    .scie_valid(b_scie_valid), .scie_insn(b_scie_insn), .scie_rs1(b_scie_rs1), .scie_rs2(b_scie_rs2),
    .scie_rd(b_scie_rd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result), .busy(b_busy)
  );

  // SCIE pipeline stubs: the result is valid only on the cycle exactly
  // RESULT_LATENCY cycles after the compute issue, junk otherwise.
  always @(posedge clock) begin
    if (a_reset) a_pend <= 0;
    else if (a_scie_valid && a_scie_insn == 32'h0000_005B) a_pend <= 1;
    else if (a_pend != 0) a_pend <= a_pend - 1;
  end
  assign a_scie_rd = (a_pend == 1) ? a_rd_val : JUNK;

  always @(posedge clock) begin
    if (b_reset) b_pend <= 0;
    else if (b_scie_valid && b_scie_insn == 32'h0000_005B) b_pend <= 3;
    else if (b_pend != 0) b_pend <= b_pend - 1;
  end
  assign b_scie_rd = (b_pend == 1) ? b_rd_val : JUNK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Compare process for the default instance: issue stream against the
  // expected queue, idle-zero operands, handshake exclusivity, result value.
  always @(negedge clock) begin : cmp
    issue_t e;
    issue_t o;
    if (chk_en) begin
      if (a_scie_valid === 1'b1) begin
        o.insn = a_scie_insn; o.rs1 = a_scie_rs1; o.rs2 = a_scie_rs2;
        obs_q.push_back(o);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL issue_unexpected: got insn 0x%08h rs1 0x%08h rs2 0x%08h expected no issue",
                   a_scie_insn, a_scie_rs1, a_scie_rs2);
        end else begin
          e = exp_q.pop_front();
          chk("issue_insn", a_scie_insn, e.insn);
          chk("issue_rs1", a_scie_rs1, e.rs1);
          chk("issue_rs2", a_scie_rs2, e.rs2);
        end
      end else begin
        chk("idle_insn", a_scie_insn, 32'h0);
        chk("idle_rs1", a_scie_rs1, 32'h0);
        chk("idle_rs2", a_scie_rs2, 32'h0);
      end
      if (a_in_ready) chk("ready_excl", {30'b0, a_scie_valid, a_out_valid}, 32'h0);
      if (a_out_valid) chk("out_result", a_out_result, a_rd_val);
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_in_ready"}, 32'(a_in_ready), 32'h1);
    chk({tag, "_scie_valid"}, 32'(a_scie_valid), 32'h0);
    chk({tag, "_insn"}, a_scie_insn, 32'h0);
    chk({tag, "_rs1"}, a_scie_rs1, 32'h0);
    chk({tag, "_rs2"}, a_scie_rs2, 32'h0);
    chk({tag, "_out_valid"}, 32'(a_out_valid), 32'h0);
    chk({tag, "_out_result"}, a_out_result, 32'h0);
    chk({tag, "_busy"}, 32'(a_busy), 32'h0);
  endtask

  task automatic run_frame_a(input logic [15:0] c [5], input logic [15:0] s [5],
                             input bit gappy, input int stall, input logic [31:0] rd,
                             input int reset_at, output int cycles, output int ov_cycles,
                             output logic [31:0] res);
    int k, idle, t, left;
    bit started, done, hs_in, hs_out;
    issue_t e;
    k = 0; idle = 0; t = 0; left = stall;
    started = 0; done = 0; cycles = 0; ov_cycles = 0; res = 32'h0;
    a_rd_val = rd;
    for (int i = 0; i < 5; i++) begin
      e.insn = 32'h0000_000B; e.rs1 = 32'(c[i]); e.rs2 = 32'(i); exp_q.push_back(e);
      e.insn = 32'h0000_002B; e.rs1 = 32'(s[i]); e.rs2 = 32'(i); exp_q.push_back(e);
    end
    e.insn = 32'h0000_005B; e.rs1 = 32'h0; e.rs2 = 32'h0; exp_q.push_back(e);
    while (!done && t < 300) begin
      a_in_valid = (k < 5) && (idle == 0);
      if (k < 5) begin
        a_in_coef = c[k];
        a_in_sample = s[k];
      end
      a_out_ready = a_out_valid && (left == 0);
      hs_in  = a_in_valid && a_in_ready;
      hs_out = a_out_valid && a_out_ready;
      if (hs_in && k == 0) started = 1;
      if (started) cycles++;
      if (a_in_ready && !a_in_valid) begin
        chk("wait_no_issue", 32'(a_scie_valid), 32'h0);
        chk("wait_busy", 32'(a_busy), 32'(k != 0));
        idle--;
      end
      if (a_out_valid) begin
        ov_cycles++;
        if (ov_cycles == 1) res = a_out_result;
        else begin
          chk("hold_result", a_out_result, res);
          chk("hold_in_ready", 32'(a_in_ready), 32'h0);
        end
        if (left > 0) left--;
      end
      if (reset_at >= 0 && a_scie_valid && a_scie_insn == 32'h0000_002B &&
          a_scie_rs2 == 32'(reset_at)) begin
        a_reset = 1'b1;
        a_in_valid = 1'b0;
        step();
        a_reset = 1'b0;
        exp_q.delete();
        chk_reset_a("midreset");
        return;
      end
      step();
      t++;
      if (hs_in) begin
        k++;
        if (gappy) idle = 2;
      end
      if (hs_out) done = 1;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL frame_timeout: got no result handshake in 300 cycles, expected one");
    end else begin
      chk("post_in_ready", 32'(a_in_ready), 32'h1);
      chk("post_busy", 32'(a_busy), 32'h0);
    end
  endtask

  logic [15:0] f1_c [5] = '{16'd45838, 16'd53395, 16'd65001, 16'd58774, 16'd7161};
  logic [15:0] f1_s [5] = '{16'd54205, 16'd36688, 16'd1523, 16'd54904, 16'd56750};
  logic [15:0] f2_c [5] = '{16'd100, 16'd300, 16'd65535, 16'd0, 16'd4660};
  logic [15:0] f2_s [5] = '{16'd200, 16'd400, 16'd1, 16'd65535, 16'd22136};
  logic [15:0] f3_c [5] = '{16'd11, 16'd13, 16'd15, 16'd17, 16'd19};
  logic [15:0] f3_s [5] = '{16'd12, 16'd14, 16'd16, 16'd18, 16'd20};
  logic [15:0] f4_c [5] = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd9};
  logic [15:0] f4_s [5] = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10};

  // TAPS=1 / latency 3 cycle table, starting in ACCEPT.
  logic        bt_valid [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] bt_insn  [9] = '{32'h0, 32'h0B, 32'h2B, 32'h5B, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] bt_rs1   [9] = '{32'h0, 32'h1234, 32'h5678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        bt_ov    [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        bt_ir    [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        bt_busy  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int cyc, ov;
    logic [31:0] res;
    a_reset = 1'b1; a_in_valid = 1'b0; a_in_coef = '0; a_in_sample = '0; a_out_ready = 1'b0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_in_coef = '0; b_in_sample = '0; b_out_ready = 1'b0;
    a_rd_val = 32'h0; b_rd_val = 32'h0;
    step();
    step();
    chk_reset_a("reset");
    chk("b_reset_in_ready", 32'(b_in_ready), 32'h1);
    chk("b_reset_out_valid", 32'(b_out_valid), 32'h0);
    a_reset = 1'b0;
    b_reset = 1'b0;
    chk_en = 1'b1;

    // Frame 1: published vectors, no back-pressure.
    run_frame_a(f1_c, f1_s, 1'b0, 0, 32'd124761, -1, cyc, ov, res);
    chk("f1_frame_cycles", 32'(cyc), 32'd18);
    chk("f1_out_valid_cycles", 32'(ov), 32'd1);
    chk("f1_result", res, 32'd124761);
    chk("f1_obs_count", 32'(obs_q.size()), 32'd11);
    if (obs_q.size() == 11) begin
      chk("f1_first_insn", obs_q[0].insn, 32'h0000_000B);
      chk("f1_first_rs1", obs_q[0].rs1, 32'd45838);
      chk("f1_second_rs1", obs_q[1].rs1, 32'd54205);
      chk("f1_last_load_rs1", obs_q[9].rs1, 32'd56750);
      chk("f1_last_load_rs2", obs_q[9].rs2, 32'd4);
      chk("f1_compute_insn", obs_q[10].insn, 32'h0000_005B);
    end

    // Frame 2: in_valid gaps in ACCEPT, 10-cycle stall in HOLD, negative result.
    run_frame_a(f2_c, f2_s, 1'b1, 10, 32'hFFFF_8001, -1, cyc, ov, res);
    chk("f2_frame_cycles", 32'(cyc), 32'd36);
    chk("f2_out_valid_cycles", 32'(ov), 32'd11);
    chk("f2_result", res, 32'hFFFF_8001);

    // Frame 3: reset during ISSUE_S of tap 2; the rest of the frame is dropped.
    run_frame_a(f3_c, f3_s, 1'b0, 0, 32'h1111_2222, 2, cyc, ov, res);
    chk("f3_no_result", 32'(ov), 32'd0);

    // Frame 4: starts cleanly from tap 0 after the reset.
    run_frame_a(f4_c, f4_s, 1'b0, 0, 32'h7FFF_FFFF, -1, cyc, ov, res);
    chk("f4_frame_cycles", 32'(cyc), 32'd18);
    chk("f4_result", res, 32'h7FFF_FFFF);
    step();
    chk("a_expected_drained", 32'(exp_q.size()), 32'd0);

    // TAPS=1, RESULT_LATENCY=3: 8-cycle frame.
    b_rd_val = 32'h8000_0001;
    b_in_coef = 16'h1234;
    b_in_sample = 16'h5678;
    b_out_ready = 1'b1;
    b_in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b_valid_c%0d", i), 32'(b_scie_valid), 32'(bt_valid[i]));
      chk($sformatf("b_insn_c%0d", i), b_scie_insn, bt_insn[i]);
      chk($sformatf("b_rs1_c%0d", i), b_scie_rs1, bt_rs1[i]);
      chk($sformatf("b_rs2_c%0d", i), b_scie_rs2, 32'h0);
      chk($sformatf("b_out_valid_c%0d", i), 32'(b_out_valid), 32'(bt_ov[i]));
      chk($sformatf("b_in_ready_c%0d", i), 32'(b_in_ready), 32'(bt_ir[i]));
      chk($sformatf("b_busy_c%0d", i), 32'(b_busy), 32'(bt_busy[i]));
      if (bt_ov[i]) chk("b_result", b_out_result, 32'h8000_0001);
      step();
      if (i == 0) b_in_valid = 1'b0;
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200us, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/scie_fir_sequencer.md
SCIE_FIR_SEQUENCER -- requirements
Module: scie_fir_sequencer

Interface
REQ-001 Parameter TAPS, default 5: number of coefficient/sample pairs per FIR frame, range 1..16.
REQ-002 Parameter RESULT_LATENCY, default 1: cycles from the compute issue to a valid scie_rd, range 1..4.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  a coefficient/sample pair is offered.
REQ-006 in_ready  output  1  the sequencer accepts the offered pair this cycle.
REQ-007 in_coef  input  16  coefficient, unsigned bit pattern.
REQ-008 in_sample  input  16  sample, unsigned bit pattern.
REQ-009 scie_valid  output  1  an instruction is issued to the SCIE pipeline this cycle.
REQ-010 scie_insn  output  32  instruction word.
REQ-011 scie_rs1  output  32  operand 1.
REQ-012 scie_rs2  output  32  operand 2.
REQ-013 scie_rd  input  32  signed result from the SCIE pipeline.
REQ-014 out_valid  output  1  frame result available.
REQ-015 out_ready  input  1  downstream consumes the result.
REQ-016 out_result  output  32  signed FIR result.
REQ-017 busy  output  1  high in every state except ACCEPT with tap index 0.

Function
REQ-018 States SHALL be ACCEPT, ISSUE_C, ISSUE_S, COMPUTE, WAIT and HOLD; a tap index idx (0..TAPS-1) SHALL track the current pair.
REQ-019 ACCEPT: in_ready=1; on in_valid, register coef and sample and go to ISSUE_C; otherwise stay.
REQ-020 ISSUE_C: scie_valid=1, insn=0x0000000B, rs1=zero-extended coef, rs2=idx; next state ISSUE_S.
REQ-021 ISSUE_S: scie_valid=1, insn=0x0000002B, rs1=zero-extended sample, rs2=idx; if idx==TAPS-1 go to COMPUTE, else idx+1 and go to ACCEPT.
REQ-022 COMPUTE: scie_valid=1, insn=0x0000005B, rs1=0, rs2=0, for exactly one cycle; next state WAIT with the latency counter loaded.
REQ-023 WAIT SHALL last RESULT_LATENCY cycles, with scie_valid=0; on its last cycle, scie_rd SHALL be registered into out_result and the state SHALL move to HOLD.
REQ-024 HOLD: out_valid=1 and out_result stable; on out_ready, clear idx to 0 and go to ACCEPT, otherwise stay.
REQ-025 When scie_valid=0, scie_insn, scie_rs1 and scie_rs2 SHALL all be driven to 0.
REQ-026 in_ready SHALL be 0 in every state except ACCEPT; a pair offered outside ACCEPT is not consumed and SHALL be held by the source.
REQ-027 With in_valid and out_ready held at 1, a frame SHALL take 3*TAPS+RESULT_LATENCY+2 cycles (18 for the defaults).
REQ-028 TAPS=1 SHALL go straight from ISSUE_S to COMPUTE after one pair.
REQ-029 No arithmetic SHALL be applied to scie_rd; it is passed through bit-exact.
REQ-030 Back-to-back frames: the first ACCEPT cycle after the HOLD handshake SHALL accept the next frame's idx 0 pair.

Reset
REQ-031 A reset in any state SHALL force ACCEPT, idx=0, latency counter=0, in_ready=1, scie_valid=0, scie_insn=scie_rs1=scie_rs2=0, out_valid=0, out_result=0 and busy=0 on the next cycle.
REQ-032 A reset mid-frame SHALL discard partial progress, with no compute issued; the SCIE pipeline SHALL share the same reset.

Structure
REQ-033 Package scie_fir_pkg SHALL hold the opcode constants OP_LD_COEF=0x0B, OP_LD_SAMPLE=0x2B and OP_COMPUTE=0x5B, the state enum, and the default TAPS and RESULT_LATENCY values.
REQ-034 The block SHALL be a single module with no sub-module; the FSM, idx counter, latency counter and result register are local.

Verification
REQ-035 Defaults; pairs (45838,54205),(53395,36688),(65001,1523),(58774,54904),(7161,56750); in_valid=1 -> the issue stream is 0x0B/idx0/45838, 0x2B/idx0/54205, ..., 0x2B/idx4/56750, then 0x5B/0/0.
REQ-036 Stub drives scie_rd=124761 RESULT_LATENCY cycles after the compute issue; out_ready=1 -> out_valid pulses for 1 cycle with out_result=124761, and the frame takes 18 cycles.
REQ-037 out_ready=0 for 10 cycles in HOLD -> out_valid and out_result stay stable and in_ready stays 0; out_ready=1 -> ACCEPT and idx=0.
REQ-038 in_valid toggles 1,0,0,1,... -> no instruction is issued while waiting, and idx advances only on a handshake.
REQ-039 Reset asserted in ISSUE_S at idx=2 -> all outputs are at reset values next cycle, and the next frame starts at idx 0 with no 0x5B issued.
REQ-040 TAPS=1 and RESULT_LATENCY=3 -> the sequence is 0x0B, 0x2B, 0x5B, 3 WAIT cycles, then HOLD, for a total of 8 cycles.
